// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the seven-segment bus reader
//
// Purpose: segment code constants (active-low, bit 6 = g .. bit 0 = a),
// bus widths and the sampler state type used by seg_capture and seg_decode.
// Ports: none (package).
package seg_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h18;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_HOLD
  } samp_state_e;

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - seven-segment pattern to hex nibble decoder
//
// Purpose: combinational map of an active-low segment pattern to its nibble.
// Ports:
//   pat_i  in  7  segment pattern, active-low, g..a
//   nib_o  out 4  decoded nibble (0 for an unknown pattern)
//   bad_o  out 1  pattern is not one of the sixteen legal codes
module seg_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic [3:0]       nib_o,
  output logic             bad_o
);

  always_comb begin
    nib_o = 4'h0;
    bad_o = 1'b0;
    case (pat_i)
      SEG_0:   nib_o = 4'h0;
      SEG_1:   nib_o = 4'h1;
      SEG_2:   nib_o = 4'h2;
      SEG_3:   nib_o = 4'h3;
      SEG_4:   nib_o = 4'h4;
      SEG_5:   nib_o = 4'h5;
      SEG_6:   nib_o = 4'h6;
      SEG_7:   nib_o = 4'h7;
      SEG_8:   nib_o = 4'h8;
      SEG_9:   nib_o = 4'h9;
      SEG_A:   nib_o = 4'hA;
      SEG_B:   nib_o = 4'hB;
      SEG_C:   nib_o = 4'hC;
      SEG_D:   nib_o = 4'hD;
      SEG_E:   nib_o = 4'hE;
      SEG_F:   nib_o = 4'hF;
      default: bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - multiplexed seven-segment display bus reader
//
// Purpose: synchronizes the segment/anode lines, accepts a digit once its
// pattern has been stable for STABLE_CYCLES samples, and presents a full
// four-digit scan frame as a 16-bit value on a valid/ready output.
// Ports:
//   clk      in  1   clock
//   rst_n    in  1   asynchronous active-low reset
//   seg_n    in  7   segment lines, active-low, g..a
//   an_n     in  4   digit enables, active-low, bit i = digit i
//   value    out 16  captured value, digit i at [4i+3:4i]
//   bad      out 4   per-digit illegal-pattern flag
//   valid    out 1   value/bad presented
//   ready    in  1   consumer accept
//   overrun  out 1   sticky: a completed frame was dropped
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_n,
  input  logic [DIGITS-1:0] an_n,
  output logic [15:0]      value,
  output logic [DIGITS-1:0] bad,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int          TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Two-flop synchronizers; reset to the blank (all lines high) bus state.
  logic [SEG_W-1:0]  seg_s1_q, seg_s2_q;
  logic [DIGITS-1:0] an_s1_q, an_s2_q;

  samp_state_e       state_q, state_d;
  logic [1:0]        dig_q, dig_d;
  logic [SEG_W-1:0]  pat_q, pat_d;
  logic [7:0]        stab_q, stab_d;

  logic [DIGITS-1:0][3:0] shd_val_q;
  logic [DIGITS-1:0]      shd_bad_q;
  logic [DIGITS-1:0]      seen_q, seen_d;
  logic [TO_W-1:0]        to_q, to_d;

  logic [15:0]       value_q;
  logic [DIGITS-1:0] bad_q;
  logic              valid_q, overrun_q;

  logic       onehot, changed, capture, restart;
  logic [1:0] an_idx;
  logic [3:0] dec_nib;
  logic       dec_bad;
  logic       frame_done, load_out, timeout_hit;

  seg_decode u_dec (
    .pat_i (seg_s2_q),
    .nib_o (dec_nib),
    .bad_o (dec_bad)
  );

  always_comb begin
    onehot = ($countones(~an_s2_q) == 1);
    an_idx = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s2_q[i]) an_idx = i[1:0];
    end
    changed = !onehot || (an_idx != dig_q) || (seg_s2_q != pat_q);
  end

  // Sampler next state. A change sample is re-evaluated as if in IDLE in the
  // same cycle, so a new digit starts its stability count without a gap.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    pat_d   = pat_q;
    stab_d  = stab_q;
    capture = 1'b0;
    restart = 1'b0;
    case (state_q)
      ST_TRACK: begin
        if (changed) begin
          restart = 1'b1;
        end else if (stab_q + 8'd1 == STAB_LAST) begin
          stab_d  = STAB_LAST;
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          stab_d = stab_q + 8'd1;
        end
      end
      ST_HOLD:  restart = changed;
      default:  restart = 1'b1;
    endcase
    if (restart) begin
      if (onehot) begin
        dig_d  = an_idx;
        pat_d  = seg_s2_q;
        stab_d = 8'd1;
        if (STABLE_CYCLES == 1) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_TRACK;
        end
      end else begin
        stab_d  = 8'd0;
        state_d = ST_IDLE;
      end
    end
  end

  // Frame assembly and timeout. Only blanking samples advance the timeout.
  always_comb begin
    frame_done  = &seen_q;
    load_out    = frame_done && (!valid_q || ready);
    timeout_hit = !onehot && (to_q == TO_LAST);
    to_d        = to_q;
    if (capture)          to_d = '0;
    else if (timeout_hit) to_d = '0;
    else if (!onehot)     to_d = to_q + TO_W'(1);
    seen_d = seen_q;
    if (frame_done || timeout_hit) seen_d = '0;
    if (capture) seen_d[dig_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      state_q  <= ST_IDLE;
      dig_q    <= '0;
      pat_q    <= '0;
      stab_q   <= '0;
    end else begin
      seg_s1_q <= seg_n;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_n;
      an_s2_q  <= an_s1_q;
      state_q  <= state_d;
      dig_q    <= dig_d;
      pat_q    <= pat_d;
      stab_q   <= stab_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_val_q <= '0;
      shd_bad_q <= '0;
      seen_q    <= '0;
      to_q      <= '0;
      value_q   <= '0;
      bad_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
      to_q   <= to_d;
      if (capture) begin
        shd_val_q[dig_d] <= dec_nib;
        shd_bad_q[dig_d] <= dec_bad;
      end
      // The output takes the shadow as it stood before this cycle's capture.
      if (load_out) begin
        value_q <= shd_val_q;
        bad_q   <= shd_bad_q;
        valid_q <= 1'b1;
      end else if (frame_done) begin
        overrun_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign value   = value_q;
  assign bad     = bad_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule
